// File: rtl/n_eight_bit_pkg.sv
// Shared definitions for the n_eight_bit byte producer/receiver pair.
package n_eight_bit_pkg;
  localparam int DATA_W_DEF    = 8;
  localparam int NUM_BYTES_DEF = 8;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} rx_state_t;

  // Sum width wide enough that NUM_BYTES full-scale bytes never overflow.
  function automatic int sum_w_f(input int data_w, input int num_bytes);
    return data_w + $clog2(num_bytes);
  endfunction
endpackage

// File: rtl/n_eight_bit_accum.sv
// Running byte accumulator and beat counter for one frame.
module n_eight_bit_accum #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3,
  parameter int SUM_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add_en,
  input  logic              last_rel,
  input  logic              clr,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  acc,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              wrap
);
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + {{CNT_W{1'b0}}, data};
      cnt_d = cnt_q + CNT_W'(1);
    end else if (last_rel) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc      = acc_q;
  assign beat_cnt = cnt_q;
  // Counter back at zero while in ACK means the final beat of the frame was taken.
  assign wrap     = (cnt_q == '0);
endmodule

// File: rtl/n_eight_bit_rx.sv
// Four-phase req/ack byte receiver; sums NUM_BYTES bytes per frame.
module n_eight_bit_rx
  import n_eight_bit_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int CNT_W     = $clog2(NUM_BYTES),
  parameter int SUM_W     = sum_w_f(DATA_W, NUM_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  output logic              ack,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              busy,
  output logic [SUM_W-1:0]  sum,
  output logic              sum_valid
);
  rx_state_t        state_q;
  logic             ack_q, sum_valid_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] acc;
  logic             wrap, add_en, last_rel;

  assign add_en   = clear && (state_q == IDLE) && req && en;
  assign last_rel = clear && (state_q == ACK) && !req && wrap;

  n_eight_bit_accum #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_accum (
    .clk      (clk),
    .rst_n    (reset),
    .add_en   (add_en),
    .last_rel (last_rel),
    .clr      (!clear),
    .data     (a),
    .acc      (acc),
    .beat_cnt (beat_cnt),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      if (!clear) begin
        // Abort drops the partial frame but keeps the last good sum.
        state_q <= IDLE;
        ack_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (req && en) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
          ACK: if (!req) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
            if (wrap) begin
              sum_q       <= acc;
              sum_valid_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ack       = ack_q;
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = ack_q || (beat_cnt != '0);
endmodule

// File: tb/tb_n_eight_bit_rx.sv
// Directed bench for n_eight_bit_rx with a queue of expected frame sums.
module tb_n_eight_bit_rx;
  logic        clk = 1'b0;
  logic        reset, clear, req, en;
  logic [7:0]  a;
  logic        ack, busy, sum_valid;
  logic [2:0]  beat_cnt;
  logic [10:0] sum;

  int checks = 0;
  int errors = 0;

  int          m_cnt;
  int          m_acc;
  int          m_last;
  int          exp_q[$];

  n_eight_bit_rx dut (
    .clk(clk), .reset(reset), .clear(clear), .req(req), .en(en), .a(a),
    .ack(ack), .beat_cnt(beat_cnt), .busy(busy), .sum(sum), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sum_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_sum_valid", 32'd1, 32'd0);
      else chk("sum", {21'd0, sum}, exp_q.pop_front());
    end
  end

  // One handshake: req held 'hold' cycles, then released for one cycle.
  task automatic send_byte(input logic [7:0] b, input int hold, input bit clr_rel);
    req = 1'b1; en = 1'b1; a = b;
    repeat (hold) @(negedge clk);
    m_acc += b;
    m_cnt = (m_cnt + 1) % 8;
    chk("ack_hi", {31'd0, ack}, 32'd1);
    chk("beat_cnt", {29'd0, beat_cnt}, m_cnt);
    chk("busy_hi", {31'd0, busy}, 32'd1);
    req = 1'b0; en = $urandom_range(0, 1); a = 8'($urandom);
    if (clr_rel) begin
      clear = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      m_acc = 0; m_cnt = 0;
      chk("clr_rel_valid", {31'd0, sum_valid}, 32'd0);
      chk("clr_rel_sum", {21'd0, sum}, m_last);
    end else begin
      if (m_cnt == 0) begin
        exp_q.push_back(m_acc);
        m_last = m_acc;
        m_acc = 0;
      end
      @(negedge clk);
    end
    chk("ack_lo", {31'd0, ack}, 32'd0);
    chk("busy_rel", {31'd0, busy}, (m_cnt != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] b, input int hold);
    for (int i = 0; i < 8; i++) send_byte(b, hold, 1'b0);
  endtask

  initial begin
    m_cnt = 0; m_acc = 0; m_last = 0;
    reset = 1'b0; clear = 1'b1; req = 1'b0; en = 1'b0; a = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_cnt", {29'd0, beat_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {21'd0, sum}, 32'd0);
    chk("rst_valid", {31'd0, sum_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 1; i <= 8; i++) send_byte(8'(i), 2, 1'b0);
    @(negedge clk);
    chk("sum_hold36", {21'd0, sum}, 32'd36);

    // req with en=0 must be ignored
    req = 1'b1; en = 1'b0; a = 8'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("en0_no_ack", {31'd0, ack}, 32'd0);
    end
    send_byte(8'h10, 1, 1'b0);
    send_byte(8'h05, 1, 1'b0);
    send_byte(8'h05, 1, 1'b0);
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    m_acc = 0; m_cnt = 0;
    chk("clr_cnt", {29'd0, beat_cnt}, 32'd0);
    chk("clr_sum_held", {21'd0, sum}, 32'd36);
    send_frame(8'h02, 2);

    send_frame(8'hFF, 2);
    for (int i = 0; i < 7; i++) send_byte(8'h03, 1, 1'b0);
    send_byte(8'h03, 1, 1'b1);
    send_frame(8'h00, 2);

    // Back-to-back, plus long req holds that must not duplicate a capture
    send_frame(8'h80, 1);
    @(negedge clk);
    chk("sum_1024", {21'd0, sum}, 32'd1024);

    for (int i = 0; i < 4; i++) send_byte(8'h11, 3, 1'b0);
    req = 1'b1; en = 1'b1; a = 8'h11;
    @(negedge clk);
    chk("pre_rst_ack", {31'd0, ack}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_ack", {31'd0, ack}, 32'd0);
    chk("arst_cnt", {29'd0, beat_cnt}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_sum", {21'd0, sum}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b1;
    m_acc = 0; m_cnt = 0; m_last = 0;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 3), 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
